// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode constants, bubble word and FSM state type for the pipeline control sequencer.
package pipe_ctrl_pkg;

  localparam logic [4:0] OP_HALT  = 5'b11100;
  localparam logic [4:0] OP_STORE = 5'b11110;
  localparam logic [4:0] OP_LOAD  = 5'b11111;

  // Branch and jump are identified by their 3-bit opcode prefix.
  localparam logic [2:0] OP_BRANCH_PFX = 3'b101;
  localparam logic [2:0] OP_JUMP_PFX   = 3'b110;

  localparam logic [15:0] NOP_WORD_DEF = 16'hE800;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } ctrl_state_e;

  function automatic logic is_ctrl_xfer(input logic [4:0] op);
    return (op[4:2] == OP_BRANCH_PFX) || (op[4:2] == OP_JUMP_PFX);
  endfunction

endpackage

// File: rtl/pipe_hazard_det.sv
// Combinational hazard detection between decode (stage 1) and execute (stage 2):
// load-use dependency and control-transfer kill of the younger stage.
module pipe_hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic       s1_valid,
  input  logic [2:0] s1_rs,
  input  logic [2:0] s1_rt,
  input  logic       s2_valid,
  input  logic [4:0] s2_op,
  input  logic [2:0] s2_rd,
  output logic       load_use,
  output logic       branch_kill
);

  assign load_use = s2_valid && (s2_op == OP_LOAD) && s1_valid &&
                    ((s1_rs == s2_rd) || (s1_rt == s2_rd));

  assign branch_kill = s2_valid && is_ctrl_xfer(s2_op);

endmodule

// File: rtl/pipe_ctrl_seq.sv
// Pipeline control sequencer: per-stage word/valid tracking, load-use bubbles, flush,
// halt drain FSM and ExtStall freeze. Define PIPE_CTRL_PERF_EN to add PerfCnt/PerfClr.
module pipe_ctrl_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int            IW       = 16,
  parameter int            STAGES   = 5,
  parameter logic [IW-1:0] NOP_WORD = IW'(NOP_WORD_DEF),
  parameter int            RD_LSB   = 8,
  parameter int            RS_LSB   = 5,
  parameter int            RT_LSB   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IW-1:0]        InstrIn,
  input  logic                 InstrValid,
  input  logic                 ExtStall,
  input  logic                 Redirect,
  input  logic                 Resume,
  output logic [STAGES*IW-1:0] StageInstr,
  output logic [STAGES-1:0]    StageValid,
  output logic                 FetchStall,
  output logic                 Flush,
  output logic                 Halted,
  output logic                 Draining
`ifdef PIPE_CTRL_PERF_EN
  ,
  input  logic                 PerfClr,
  output logic [95:0]          PerfCnt
`endif
);

  localparam int CW = $clog2(STAGES);

  logic [IW-1:0]     stage_q [STAGES];
  logic [IW-1:0]     stage_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  ctrl_state_e       state_q;
  ctrl_state_e       state_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;

  logic load_use;
  logic branch_kill;
  logic freeze;
  logic flush;
  logic lu_stall;
  logic s1_halt;

  pipe_hazard_det u_hazard (
    .s1_valid    (valid_q[0]),
    .s1_rs       (stage_q[0][RS_LSB +: 3]),
    .s1_rt       (stage_q[0][RT_LSB +: 3]),
    .s2_valid    (valid_q[1]),
    .s2_op       (stage_q[1][IW-1 -: 5]),
    .s2_rd       (stage_q[1][RD_LSB +: 3]),
    .load_use    (load_use),
    .branch_kill (branch_kill)
  );

  // HALTED freezes the stages like ExtStall does, so neither flush nor load-use may act then.
  assign freeze   = ExtStall || (state_q == HALTED);
  assign flush    = !freeze && (Redirect || branch_kill);
  assign lu_stall = !freeze && !flush && load_use;
  assign s1_halt  = valid_q[0] && (stage_q[0][IW-1 -: 5] == OP_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= NOP_WORD;
      valid_q <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
      valid_q <= valid_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) stage_d[k] = stage_q[k];
    valid_d = valid_q;
    if (!freeze) begin
      for (int k = 2; k < STAGES; k++) begin
        stage_d[k] = stage_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      if (flush || lu_stall) begin
        stage_d[1] = NOP_WORD;
        valid_d[1] = 1'b0;
      end else begin
        stage_d[1] = stage_q[0];
        valid_d[1] = valid_q[0];
      end
      // A flushed fetch word is still captured but marked dead; a load-use holds stage 1.
      if (flush) begin
        stage_d[0] = InstrIn;
        valid_d[0] = 1'b0;
      end else if (!lu_stall) begin
        if (state_q == RUN) begin
          stage_d[0] = InstrIn;
          valid_d[0] = InstrValid;
        end else begin
          stage_d[0] = NOP_WORD;
          valid_d[0] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!ExtStall) begin
      unique case (state_q)
        RUN: begin
          if (s1_halt && !flush && !lu_stall) begin
            state_d = DRAIN;
            cnt_d   = CW'(STAGES - 1);
          end
        end
        DRAIN: begin
          if (cnt_q <= CW'(1)) begin
            state_d = HALTED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        HALTED: begin
          if (Resume) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_flat
    assign StageInstr[g*IW +: IW] = stage_q[g];
  end

  assign StageValid = valid_q;
  assign FetchStall = ExtStall || (state_q != RUN) || lu_stall;
  assign Flush      = flush;
  assign Halted     = (state_q == HALTED);
  assign Draining   = (state_q == DRAIN);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;
  logic [31:0] perf_ext_q;

  // Event counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_ext_q   <= '0;
    end else if (PerfClr) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_ext_q   <= '0;
    end else begin
      if (lu_stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush && (perf_flush_q != '1))    perf_flush_q <= perf_flush_q + 32'd1;
      if (ExtStall && (perf_ext_q != '1))   perf_ext_q   <= perf_ext_q + 32'd1;
    end
  end

  assign PerfCnt = {perf_ext_q, perf_flush_q, perf_stall_q};
`endif

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Testbench for pipe_ctrl_seq: table-driven vectors fed through an expected-value queue,
// plus hand-built halt/drain, flush and reset sequences.
module tb_pipe_ctrl_seq;
  import pipe_ctrl_pkg::*;

  localparam int IW = 16;
  localparam int STAGES = 5;
  localparam logic [15:0] NOP = 16'hE800;

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 2'b00};
  endfunction

  localparam logic [15:0] A1  = mk(5'b00000, 3'd1, 3'd0, 3'd0);
  localparam logic [15:0] A2  = mk(5'b00000, 3'd2, 3'd0, 3'd0);
  localparam logic [15:0] A3  = mk(5'b00000, 3'd3, 3'd0, 3'd0);
  localparam logic [15:0] A4  = mk(5'b00000, 3'd4, 3'd0, 3'd0);
  localparam logic [15:0] A5  = mk(5'b00000, 3'd5, 3'd0, 3'd0);
  localparam logic [15:0] A6  = mk(5'b00000, 3'd7, 3'd0, 3'd0);
  localparam logic [15:0] A7  = mk(5'b00000, 3'd0, 3'd7, 3'd7);
  localparam logic [15:0] A8  = mk(5'b00000, 3'd1, 3'd1, 3'd1);
  localparam logic [15:0] A9  = mk(5'b00000, 3'd2, 3'd2, 3'd2);
  localparam logic [15:0] A10 = mk(5'b00000, 3'd4, 3'd4, 3'd4);
  localparam logic [15:0] LD  = mk(5'b11111, 3'd3, 3'd0, 3'd0);
  localparam logic [15:0] USE = mk(5'b00000, 3'd6, 3'd3, 3'd0);
  localparam logic [15:0] US2 = mk(5'b00000, 3'd1, 3'd0, 3'd3);
  localparam logic [15:0] BR  = mk(5'b10100, 3'd0, 3'd0, 3'd0);
  localparam logic [15:0] JMP = mk(5'b11000, 3'd0, 3'd0, 3'd0);
  localparam logic [15:0] HLT = mk(5'b11100, 3'd0, 3'd0, 3'd0);

  logic clk = 1'b0;
  logic rst_n;
  logic [IW-1:0] instr_in;
  logic instr_valid, ext_stall, redirect, resume;
  logic [STAGES*IW-1:0] stage_instr;
  logic [STAGES-1:0] stage_valid;
  logic fetch_stall, flush, halted, draining;
`ifdef PIPE_CTRL_PERF_EN
  logic perf_clr;
  logic [95:0] perf_cnt;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipe_ctrl_seq dut (
    .clk        (clk),
    .rst        (rst_n),
    .InstrIn    (instr_in),
    .InstrValid (instr_valid),
    .ExtStall   (ext_stall),
    .Redirect   (redirect),
    .Resume     (resume),
    .StageInstr (stage_instr),
    .StageValid (stage_valid),
    .FetchStall (fetch_stall),
    .Flush      (flush),
    .Halted     (halted),
    .Draining   (draining)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .PerfClr    (perf_clr),
    .PerfCnt    (perf_cnt)
`endif
  );

  typedef struct {
    int          id;
    logic [15:0] instr;
    logic        ivalid, ext, redir, res, full;
    logic [4:0]  e_valid;
    logic [15:0] e_s1, e_s2, e_sl;
    logic        e_fstall, e_flush, e_halted, e_drain;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[$];

  function automatic vec_t mkv(input int id, input logic [15:0] instr, input logic ivalid,
                               input logic ext, input logic redir, input logic res,
                               input logic full, input logic [4:0] e_valid,
                               input logic [15:0] e_s1, input logic [15:0] e_s2,
                               input logic [15:0] e_sl, input logic e_fstall,
                               input logic e_flush, input logic e_halted, input logic e_drain);
    vec_t v;
    v.id = id; v.instr = instr; v.ivalid = ivalid; v.ext = ext; v.redir = redir;
    v.res = res; v.full = full; v.e_valid = e_valid; v.e_s1 = e_s1; v.e_s2 = e_s2;
    v.e_sl = e_sl; v.e_fstall = e_fstall; v.e_flush = e_flush; v.e_halted = e_halted;
    v.e_drain = e_drain;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic scoreboardCheck();
    vec_t e;
    e = exp_q.pop_front();
    checkOutput($sformatf("v%0d.fetch_stall", e.id), 96'(fetch_stall), 96'(e.e_fstall));
    checkOutput($sformatf("v%0d.flush", e.id), 96'(flush), 96'(e.e_flush));
    checkOutput($sformatf("v%0d.halted", e.id), 96'(halted), 96'(e.e_halted));
    checkOutput($sformatf("v%0d.draining", e.id), 96'(draining), 96'(e.e_drain));
    if (e.full) begin
      checkOutput($sformatf("v%0d.stage_valid", e.id), 96'(stage_valid), 96'(e.e_valid));
      checkOutput($sformatf("v%0d.stage1", e.id), 96'(stage_instr[0 +: IW]), 96'(e.e_s1));
      checkOutput($sformatf("v%0d.stage2", e.id), 96'(stage_instr[IW +: IW]), 96'(e.e_s2));
      checkOutput($sformatf("v%0d.stage_last", e.id), 96'(stage_instr[(STAGES-1)*IW +: IW]),
                  96'(e.e_sl));
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    instr_in = v.instr; instr_valid = v.ivalid; ext_stall = v.ext;
    redirect = v.redir; resume = v.res;
    exp_q.push_back(v);
    #1;
    scoreboardCheck();
  endtask

  task automatic runTable();
    foreach (tbl[i]) applyStimulus(tbl[i]);
    tbl.delete();
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    instr_in = NOP; instr_valid = 1'b0; ext_stall = 1'b0; redirect = 1'b0; resume = 1'b0;
    #1;
    checkOutput({tag, ".rst_words"}, 96'(stage_instr), 96'({STAGES{NOP}}));
    checkOutput({tag, ".rst_valid"}, 96'(stage_valid), 96'd0);
    checkOutput({tag, ".rst_flags"}, 96'({fetch_stall, flush, halted, draining}), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b1;
    instr_in = NOP; instr_valid = 1'b0; ext_stall = 1'b0; redirect = 1'b0; resume = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
    perf_clr = 1'b0;
`endif
    #2;
    doReset("init");

    // Streaming, load-use bubble, branch kill and external redirect.
    //                 id instr ivl ext rdr res full valid     s1   s2   sl   fs fl h  d
    tbl.push_back(mkv( 0, A1,  1, 0, 0, 0, 1, 5'b00000, NOP, NOP, NOP, 0, 0, 0, 0));
    tbl.push_back(mkv( 1, A2,  1, 0, 0, 0, 1, 5'b00001, A1,  NOP, NOP, 0, 0, 0, 0));
    tbl.push_back(mkv( 2, A3,  1, 0, 0, 0, 1, 5'b00011, A2,  A1,  NOP, 0, 0, 0, 0));
    tbl.push_back(mkv( 3, A4,  1, 0, 0, 0, 1, 5'b00111, A3,  A2,  NOP, 0, 0, 0, 0));
    tbl.push_back(mkv( 4, A5,  1, 0, 0, 0, 1, 5'b01111, A4,  A3,  NOP, 0, 0, 0, 0));
    tbl.push_back(mkv( 5, LD,  1, 0, 0, 0, 1, 5'b11111, A5,  A4,  A1,  0, 0, 0, 0));
    tbl.push_back(mkv( 6, USE, 1, 0, 0, 0, 1, 5'b11111, LD,  A5,  A2,  0, 0, 0, 0));
    tbl.push_back(mkv( 7, A6,  1, 0, 0, 0, 1, 5'b11111, USE, LD,  A3,  1, 0, 0, 0));
    tbl.push_back(mkv( 8, A6,  1, 0, 0, 0, 1, 5'b11101, USE, NOP, A4,  0, 0, 0, 0));
    tbl.push_back(mkv( 9, BR,  1, 0, 0, 0, 1, 5'b11011, A6,  USE, A5,  0, 0, 0, 0));
    tbl.push_back(mkv(10, A7,  1, 0, 0, 0, 1, 5'b10111, BR,  A6,  LD,  0, 0, 0, 0));
    tbl.push_back(mkv(11, A8,  1, 0, 0, 0, 1, 5'b01111, A7,  BR,  NOP, 0, 1, 0, 0));
    tbl.push_back(mkv(12, A9,  1, 0, 0, 0, 1, 5'b11100, A8,  NOP, USE, 0, 0, 0, 0));
    tbl.push_back(mkv(13, A10, 1, 0, 1, 0, 1, 5'b11001, A9,  A8,  A6,  0, 1, 0, 0));
    tbl.push_back(mkv(14, NOP, 0, 0, 0, 0, 1, 5'b10000, A10, NOP, BR,  0, 0, 0, 0));
    runTable();

    // Halt drain with a 3-cycle ExtStall freeze, ignored early Resume, then resume.
    doReset("halt");
    applyStimulus(mkv(20, HLT, 1, 0, 0, 0, 1, 5'b00000, NOP, NOP, NOP, 0, 0, 0, 0));
    applyStimulus(mkv(21, A1,  1, 0, 0, 0, 1, 5'b00001, HLT, NOP, NOP, 0, 0, 0, 0));
    applyStimulus(mkv(22, A2,  1, 0, 0, 0, 1, 5'b00011, A1,  HLT, NOP, 1, 0, 0, 1));
    for (int i = 0; i < 3; i++)
      applyStimulus(mkv(23 + i, A2, 1, 1, 0, 0, 1, 5'b00110, NOP, A1, NOP, 1, 0, 0, 1));
    applyStimulus(mkv(26, A2,  1, 0, 0, 0, 1, 5'b00110, NOP, A1,  NOP, 1, 0, 0, 1));
    applyStimulus(mkv(27, A2,  1, 0, 0, 1, 1, 5'b01100, NOP, NOP, NOP, 1, 0, 0, 1));
    applyStimulus(mkv(28, A2,  1, 0, 0, 0, 1, 5'b11000, NOP, NOP, HLT, 1, 0, 0, 1));
    applyStimulus(mkv(29, A2,  1, 0, 0, 0, 1, 5'b10000, NOP, NOP, A1,  1, 0, 1, 0));
    applyStimulus(mkv(30, A2,  1, 0, 0, 0, 1, 5'b10000, NOP, NOP, A1,  1, 0, 1, 0));
    applyStimulus(mkv(31, A2,  1, 0, 0, 1, 1, 5'b10000, NOP, NOP, A1,  1, 0, 1, 0));
    applyStimulus(mkv(32, A3,  1, 0, 0, 0, 1, 5'b10000, NOP, NOP, A1,  0, 0, 0, 0));
    applyStimulus(mkv(33, NOP, 0, 0, 0, 0, 1, 5'b00001, A3,  NOP, NOP, 0, 0, 0, 0));

    // Reset asserted while draining returns to an empty, running pipe.
    doReset("pre_drain");
    applyStimulus(mkv(40, HLT, 1, 0, 0, 0, 0, 5'b0, NOP, NOP, NOP, 0, 0, 0, 0));
    applyStimulus(mkv(41, NOP, 0, 0, 0, 0, 0, 5'b0, NOP, NOP, NOP, 0, 0, 0, 0));
    applyStimulus(mkv(42, NOP, 0, 0, 0, 0, 0, 5'b0, NOP, NOP, NOP, 1, 0, 0, 1));
    doReset("mid_drain");
    applyStimulus(mkv(43, A1,  1, 0, 0, 0, 1, 5'b00000, NOP, NOP, NOP, 0, 0, 0, 0));
    applyStimulus(mkv(44, NOP, 0, 0, 0, 0, 1, 5'b00001, A1,  NOP, NOP, 0, 0, 0, 0));

    // Jump in stage 2 with a simultaneous Redirect; a flushed halt must not start a drain.
    doReset("flush");
    applyStimulus(mkv(50, JMP, 1, 0, 0, 0, 1, 5'b00000, NOP, NOP, NOP, 0, 0, 0, 0));
    applyStimulus(mkv(51, A1,  1, 0, 0, 0, 1, 5'b00001, JMP, NOP, NOP, 0, 0, 0, 0));
    applyStimulus(mkv(52, A2,  1, 0, 1, 0, 1, 5'b00011, A1,  JMP, NOP, 0, 1, 0, 0));
    applyStimulus(mkv(53, NOP, 0, 0, 0, 0, 1, 5'b00100, A2,  NOP, NOP, 0, 0, 0, 0));
    applyStimulus(mkv(54, HLT, 1, 0, 0, 0, 1, 5'b01000, NOP, A2,  NOP, 0, 0, 0, 0));
    applyStimulus(mkv(55, A3,  1, 0, 1, 0, 1, 5'b10001, HLT, NOP, JMP, 0, 1, 0, 0));
    applyStimulus(mkv(56, NOP, 0, 0, 0, 0, 1, 5'b00000, A3,  NOP, NOP, 0, 0, 0, 0));
    applyStimulus(mkv(57, NOP, 0, 0, 0, 0, 0, 5'b0,     NOP, NOP, NOP, 0, 0, 0, 0));

`ifdef PIPE_CTRL_PERF_EN
    // Two load-use hazards (RT then RS match) and one branch kill.
    doReset("perf");
    applyStimulus(mkv(60, LD,  1, 0, 0, 0, 0, 5'b0, NOP, NOP, NOP, 0, 0, 0, 0));
    applyStimulus(mkv(61, US2, 1, 0, 0, 0, 0, 5'b0, NOP, NOP, NOP, 0, 0, 0, 0));
    applyStimulus(mkv(62, A1,  1, 0, 0, 0, 0, 5'b0, NOP, NOP, NOP, 1, 0, 0, 0));
    applyStimulus(mkv(63, A1,  1, 0, 0, 0, 0, 5'b0, NOP, NOP, NOP, 0, 0, 0, 0));
    applyStimulus(mkv(64, LD,  1, 0, 0, 0, 0, 5'b0, NOP, NOP, NOP, 0, 0, 0, 0));
    applyStimulus(mkv(65, USE, 1, 0, 0, 0, 0, 5'b0, NOP, NOP, NOP, 0, 0, 0, 0));
    applyStimulus(mkv(66, BR,  1, 0, 0, 0, 0, 5'b0, NOP, NOP, NOP, 1, 0, 0, 0));
    applyStimulus(mkv(67, BR,  1, 0, 0, 0, 0, 5'b0, NOP, NOP, NOP, 0, 0, 0, 0));
    applyStimulus(mkv(68, NOP, 0, 0, 0, 0, 0, 5'b0, NOP, NOP, NOP, 0, 0, 0, 0));
    applyStimulus(mkv(69, NOP, 0, 0, 0, 0, 0, 5'b0, NOP, NOP, NOP, 0, 1, 0, 0));
    applyStimulus(mkv(70, NOP, 0, 0, 0, 0, 0, 5'b0, NOP, NOP, NOP, 0, 0, 0, 0));
    checkOutput("perf_cnt", perf_cnt, {32'd0, 32'd1, 32'd2});
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    #1;
    checkOutput("perf_clr", perf_cnt, 96'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
